// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two result producers, the arbiter and the register-file write-back port.
// The arbiter takes the slave view; the producers and the register file side take the master view.
interface wb_arbiter_if #(
  parameter int W_RD  = 4,
  parameter int W_OPR = 32
);
  logic             v0_i;
  logic             stall0_o;
  logic [W_RD-1:0]  wb_r0_i;
  logic [W_OPR-1:0] result0_i;
  logic             v1_i;
  logic             stall1_o;
  logic [W_RD-1:0]  wb_r1_i;
  logic [W_OPR-1:0] result1_i;
  logic             wb_o;
  logic [W_RD-1:0]  wb_r_o;
  logic [W_OPR-1:0] result_o;
  logic             gnt_o;

  modport slave (
    input  v0_i, wb_r0_i, result0_i, v1_i, wb_r1_i, result1_i,
    output stall0_o, stall1_o, wb_o, wb_r_o, result_o, gnt_o
  );

  modport master (
    output v0_i, wb_r0_i, result0_i, v1_i, wb_r1_i, result1_i,
    input  stall0_o, stall1_o, wb_o, wb_r_o, result_o, gnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-port write-back arbiter with one pending slot per port and registered back-pressure.
// Round-robin by default; defining WB_FIXED_PRIO_EN makes port 0 always win a conflict.
module wb_arbiter #(
  parameter int W_RD  = 4,
  parameter int W_OPR = 32
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);
  localparam int NP = 2;

  logic [NP-1:0]    in_v;
  logic [W_RD-1:0]  in_r     [NP];
  logic [W_OPR-1:0] in_dat   [NP];

  logic [NP-1:0]    pend_v_q, pend_v_d;
  logic [W_RD-1:0]  pend_r_q   [NP];
  logic [W_RD-1:0]  pend_r_d   [NP];
  logic [W_OPR-1:0] pend_dat_q [NP];
  logic [W_OPR-1:0] pend_dat_d [NP];

  logic [NP-1:0]    acc, cand, win_sel, cap;
  logic [W_RD-1:0]  cand_r   [NP];
  logic [W_OPR-1:0] cand_dat [NP];
  logic             win_v, win;

  logic             wb_q, wb_d;
  logic [W_RD-1:0]  wb_r_q, wb_r_d;
  logic [W_OPR-1:0] result_q, result_d;
  logic             gnt_q, gnt_d;
`ifndef WB_FIXED_PRIO_EN
  logic             last_q, last_d;
`endif

  assign in_v      = {bus.v1_i, bus.v0_i};
  assign in_r[0]   = bus.wb_r0_i;
  assign in_r[1]   = bus.wb_r1_i;
  assign in_dat[0] = bus.result0_i;
  assign in_dat[1] = bus.result1_i;

  // A stalled port ignores its input; the pending entry always outranks fresh input.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_port
      assign acc[gi]        = in_v[gi] & ~pend_v_q[gi];
      assign cand[gi]       = pend_v_q[gi] | acc[gi];
      assign cand_r[gi]     = pend_v_q[gi] ? pend_r_q[gi]   : in_r[gi];
      assign cand_dat[gi]   = pend_v_q[gi] ? pend_dat_q[gi] : in_dat[gi];
      assign win_sel[gi]    = win_v & (win == 1'(gi));
      assign cap[gi]        = acc[gi] & ~win_sel[gi];
      assign pend_v_d[gi]   = cap[gi] | (pend_v_q[gi] & ~win_sel[gi]);
      assign pend_r_d[gi]   = cap[gi] ? in_r[gi]   : pend_r_q[gi];
      assign pend_dat_d[gi] = cap[gi] ? in_dat[gi] : pend_dat_q[gi];
    end
  endgenerate

  always_comb begin
    win_v    = |cand;
`ifdef WB_FIXED_PRIO_EN
    win      = ~cand[0];
`else
    // On a conflict the port that did not win last time goes first.
    win      = (&cand) ? ~last_q : cand[1];
    last_d   = win_v ? win : last_q;
`endif
    wb_d     = win_v;
    wb_r_d   = wb_r_q;
    result_d = result_q;
    gnt_d    = gnt_q;
    if (win_v) begin
      wb_r_d   = cand_r[win];
      result_d = cand_dat[win];
      gnt_d    = win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q <= '0;
      for (int i = 0; i < NP; i++) begin
        pend_r_q[i]   <= '0;
        pend_dat_q[i] <= '0;
      end
      wb_q     <= 1'b0;
      wb_r_q   <= '0;
      result_q <= '0;
      gnt_q    <= 1'b0;
`ifndef WB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      pend_v_q   <= pend_v_d;
      pend_r_q   <= pend_r_d;
      pend_dat_q <= pend_dat_d;
      wb_q       <= wb_d;
      wb_r_q     <= wb_r_d;
      result_q   <= result_d;
      gnt_q      <= gnt_d;
`ifndef WB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.stall0_o = pend_v_q[0];
  assign bus.stall1_o = pend_v_q[1];
  assign bus.wb_o     = wb_q;
  assign bus.wb_r_o   = wb_r_q;
  assign bus.result_o = result_q;
  assign bus.gnt_o    = gnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table for the corner sequences, then random traffic
// checked against a queue-based model of the arbitration rules.
module tb_wb_arbiter;
  localparam int W_RD  = 4;
  localparam int W_OPR = 32;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  wb_arbiter_if #(.W_RD(W_RD), .W_OPR(W_OPR)) bus ();

  wb_arbiter #(.W_RD(W_RD), .W_OPR(W_OPR)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [3:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [3:0]  r1;
    logic [31:0] d1;
    logic        s0;
    logic        s1;
    logic        wb;
    logic [3:0]  r;
    logic [31:0] d;
    logic        g;
  } vec_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
  } item_t;

  vec_t  tbl[$];
  item_t q0[$];
  item_t q1[$];

  function automatic void row(input logic rst, input logic v0, input logic [3:0] r0,
                              input logic [31:0] d0, input logic v1, input logic [3:0] r1,
                              input logic [31:0] d1, input logic s0, input logic s1,
                              input logic wb, input logic [3:0] r, input logic [31:0] d,
                              input logic g);
    vec_t t;
    t.rst = rst; t.v0 = v0; t.r0 = r0; t.d0 = d0; t.v1 = v1; t.r1 = r1; t.d1 = d1;
    t.s0 = s0; t.s1 = s1; t.wb = wb; t.r = r; t.d = d; t.g = g;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] r1, input logic [31:0] d1);
    bus.v0_i      = v0;
    bus.wb_r0_i   = r0;
    bus.result0_i = d0;
    bus.v1_i      = v1;
    bus.wb_r1_i   = r1;
    bus.result1_i = d1;
  endtask

  task automatic chk_out(input string tag, input logic wb, input logic [3:0] r,
                         input logic [31:0] d, input logic g);
    chk({tag, "_wb"},   64'(bus.wb_o),     64'(wb));
    chk({tag, "_r"},    64'(bus.wb_r_o),   64'(r));
    chk({tag, "_data"}, 64'(bus.result_o), 64'(d));
    chk({tag, "_gnt"},  64'(bus.gnt_o),    64'(g));
  endtask

  logic        cv0, cv1, ap0, ap1, crst, pick1, m_last;
  logic [3:0]  cr0, cr1;
  logic [31:0] cd0, cd1;
  logic        e_wb, e_g;
  logic [3:0]  e_r;
  logic [31:0] e_d;
  item_t       it;

  initial begin
`ifndef WB_FIXED_PRIO_EN
    row(L, H, 4'd2,  32'h89abcdef, L, 4'd0,  32'h0,        L, L, H, 4'd2,  32'h89abcdef, L);
    row(L, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd2,  32'h89abcdef, L);
    row(H, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd0,  32'h0,        L);
    row(L, H, 4'd3,  32'h11111111, H, 4'd4,  32'h22222222, L, L, H, 4'd3,  32'h11111111, L);
    row(L, L, 4'd0,  32'h0,        H, 4'd4,  32'h22222222, L, H, H, 4'd4,  32'h22222222, H);
    row(L, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd4,  32'h22222222, H);
    row(L, H, 4'd5,  32'ha0,       H, 4'd6,  32'hb0,       L, L, H, 4'd5,  32'ha0,       L);
    row(L, H, 4'd7,  32'ha1,       H, 4'd6,  32'hb0,       L, H, H, 4'd6,  32'hb0,       H);
    row(L, H, 4'd7,  32'ha1,       H, 4'd8,  32'hb1,       H, L, H, 4'd7,  32'ha1,       L);
    row(L, H, 4'd9,  32'ha2,       H, 4'd8,  32'hb1,       L, H, H, 4'd8,  32'hb1,       H);
    row(L, H, 4'd9,  32'ha2,       H, 4'd10, 32'hb2,       H, L, H, 4'd9,  32'ha2,       L);
    row(L, L, 4'd0,  32'h0,        H, 4'd10, 32'hb2,       L, H, H, 4'd10, 32'hb2,       H);
    row(L, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd10, 32'hb2,       H);
    for (int i = 1; i <= 5; i++)
      row(L, L, 4'd0, 32'h0, H, 4'(i), 32'hc0 + 32'(i), L, L, H, 4'(i), 32'hc0 + 32'(i), H);
    row(L, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd5,  32'hc5,       H);
    row(L, H, 4'd12, 32'hd0,       H, 4'd13, 32'hd1,       L, L, H, 4'd12, 32'hd0,       L);
    row(H, L, 4'd0,  32'h0,        H, 4'd13, 32'hd1,       L, H, L, 4'd0,  32'h0,        L);
    row(L, H, 4'd14, 32'he0,       H, 4'd15, 32'he1,       L, L, H, 4'd14, 32'he0,       L);
    row(L, L, 4'd0,  32'h0,        H, 4'd15, 32'he1,       L, H, H, 4'd15, 32'he1,       H);
    row(L, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd15, 32'he1,       H);
`else
    row(H, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd0,  32'h0,        L);
    row(L, H, 4'd1,  32'ha,        H, 4'd2,  32'hb,        L, L, H, 4'd1,  32'ha,        L);
    row(L, H, 4'd3,  32'hc,        H, 4'd2,  32'hb,        L, H, H, 4'd3,  32'hc,        L);
    row(L, H, 4'd4,  32'hd,        H, 4'd2,  32'hb,        L, H, H, 4'd4,  32'hd,        L);
    row(L, H, 4'd5,  32'he,        H, 4'd2,  32'hb,        L, H, H, 4'd5,  32'he,        L);
    row(L, L, 4'd0,  32'h0,        H, 4'd2,  32'hb,        L, H, H, 4'd2,  32'hb,        H);
    row(L, L, 4'd0,  32'h0,        L, 4'd0,  32'h0,        L, L, L, 4'd2,  32'hb,        H);
`endif

    drive(L, 4'd0, 32'h0, L, 4'd0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", L, 4'd0, 32'h0, L);
    chk("reset_stall0", 64'(bus.stall0_o), 64'(0));
    chk("reset_stall1", 64'(bus.stall1_o), 64'(0));
    $display("reset: wb=%0b stall0=%0b stall1=%0b", bus.wb_o, bus.stall0_o, bus.stall1_o);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].v0, tbl[i].r0, tbl[i].d0, tbl[i].v1, tbl[i].r1, tbl[i].d1);
      chk($sformatf("vec%0d_stall0", i), 64'(bus.stall0_o), 64'(tbl[i].s0));
      chk($sformatf("vec%0d_stall1", i), 64'(bus.stall1_o), 64'(tbl[i].s1));
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].wb, tbl[i].r, tbl[i].d, tbl[i].g);
      $display("vec%0d: rst=%0b v0=%0b v1=%0b -> wb=%0b r=%0d data=%08h gnt=%0b",
               i, tbl[i].rst, tbl[i].v0, tbl[i].v1, bus.wb_o, bus.wb_r_o, bus.result_o, bus.gnt_o);
    end

    // Random traffic; a stalled requester keeps presenting the item it is waiting to hand over.
    ap0 = 1'b0; ap1 = 1'b0; m_last = 1'b1;
    e_wb = 1'b0; e_r = '0; e_d = '0; e_g = 1'b0;
    cv0 = 1'b0; cv1 = 1'b0; cr0 = '0; cr1 = '0; cd0 = '0; cd1 = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      crst = (cyc == 0) || ($urandom_range(0, 59) == 0);
      if (q0.size() == 0 || ap0) begin
        cv0 = ($urandom_range(0, 3) != 0);
        cr0 = 4'($urandom_range(0, 3));
        cd0 = $urandom;
      end
      if (q1.size() == 0 || ap1) begin
        cv1 = ($urandom_range(0, 3) != 0);
        cr1 = 4'($urandom_range(0, 3));
        cd1 = $urandom;
      end
      reset = crst;
      drive(cv0, cr0, cd0, cv1, cr1, cd1);
      chk("rnd_stall0", 64'(bus.stall0_o), 64'(q0.size() != 0));
      chk("rnd_stall1", 64'(bus.stall1_o), 64'(q1.size() != 0));

      if (crst) begin
        q0.delete();
        q1.delete();
        m_last = 1'b1;
        ap0 = 1'b0; ap1 = 1'b0;
        e_wb = 1'b0; e_r = '0; e_d = '0; e_g = 1'b0;
      end else begin
        ap0 = cv0 && (q0.size() == 0);
        ap1 = cv1 && (q1.size() == 0);
        if (ap0) begin it.r = cr0; it.d = cd0; q0.push_back(it); end
        if (ap1) begin it.r = cr1; it.d = cd1; q1.push_back(it); end
        e_wb = 1'b0;
        if (q0.size() != 0 || q1.size() != 0) begin
`ifdef WB_FIXED_PRIO_EN
          pick1 = (q0.size() == 0);
`else
          pick1 = (q0.size() != 0 && q1.size() != 0) ? ~m_last : (q0.size() == 0);
          m_last = pick1;
`endif
          if (pick1) it = q1.pop_front();
          else       it = q0.pop_front();
          e_wb = 1'b1;
          e_r  = it.r;
          e_d  = it.d;
          e_g  = pick1;
        end
      end

      @(posedge clk);
      #1;
      chk_out("rnd", e_wb, e_r, e_d, e_g);
      $display("rnd%0d: rst=%0b v0=%0b v1=%0b -> wb=%0b r=%0d data=%08h gnt=%0b",
               cyc, crst, cv0, cv1, bus.wb_o, bus.wb_r_o, bus.result_o, bus.gnt_o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write-back port (wb_i / wb_r_i / result_i of g_reg_x16) between two result producers: port 0 (load/store unit) and port 1 (ALU).
- Each port has a one-entry pending buffer and registered back-pressure (stall_o) in the pipeline's v/stall handshake style.
- Round-robin arbitration; the winner is presented on the write-back bus one cycle later.

Parameters:
- W_RD, 4, width of the destination register index (16 registers).
- W_OPR, 32, width of the result data.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- v0_i  in  1  port 0 result valid.
- stall0_o  out  1  port 0 back-pressure; requester holds v0_i/wb_r0_i/result0_i while high.
- wb_r0_i  in  W_RD  port 0 destination register.
- result0_i  in  W_OPR  port 0 result data.
- v1_i  in  1  port 1 result valid.
- stall1_o  out  1  port 1 back-pressure.
- wb_r1_i  in  W_RD  port 1 destination register.
- result1_i  in  W_OPR  port 1 result data.
- wb_o  out  1  write-back strobe to the register file, one cycle per write.
- wb_r_o  out  W_RD  write-back register index.
- result_o  out  W_OPR  write-back data.
- gnt_o  out  1  port index that produced the current wb_o (0/1); valid only when wb_o=1.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - wb_o=0, wb_r_o=0, result_o=0, gnt_o=0.
  - Both pending buffers empty; stall0_o=0, stall1_o=0.
  - Round-robin pointer last=1, so port 0 wins the first conflict.
- Per-port state, x in {0,1}: pend_v_x, pend_r_x, pend_d_x.
  - stall_x_o = pend_v_x, driven straight from the flop.
- Input acceptance: v_x_i is accepted in a cycle only when stall_x_o=0. If stall_x_o=1, v_x_i is ignored and the requester must hold its data.
- Candidate per port:
  - If pend_v_x=1, the candidate is the pending entry.
  - Otherwise, if the input is accepted, the candidate is the input.
  - Otherwise there is no candidate.
- Arbitration each cycle:
  - One candidate only: that port wins.
  - Both ports have candidates: the port other than last wins, and last is updated to the winner.
  - With a single candidate, last is updated to the winner as well.
- Output, registered, latency 1 cycle from acceptance to wb_o:
  - A winner exists: next cycle wb_o=1, wb_r_o/result_o = winner's data, gnt_o = winner.
  - No winner: wb_o=0; wb_r_o, result_o and gnt_o hold their previous values.
- Pending update:
  - Winner from the pending buffer: pend_v cleared.
  - Loser whose candidate came from the input: input captured into pend; pend_v=1 next cycle.
  - Loser with a pending candidate: the entry is retained.
- Throughput:
  - Sustained single-port traffic: one write per cycle, never stalls.
  - Dual-port traffic: alternates 0,1,0,1, with each port stalled every other cycle.
  - Maximum wait for any accepted result is 2 cycles.
- Same-register conflict: both ports writing the same wb_r are serialized in grant order with no merging. The later grant's value is the final register content.
- Reset mid-operation: pending entries are discarded (not written back); outputs return to reset values the next cycle.
- Bus rule: wb_o is never high for more than one write per cycle; there is no combinational path from v_x_i to stall_x_o.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins a conflict, and the last pointer is not implemented. Port 1 may starve under continuous port 0 traffic.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset -> wb_o=0, stall0_o=stall1_o=0, wb_r_o=0, result_o=0; then v0_i=1 with r=2, d=32'h89abcdef for one cycle -> next cycle wb_o=1, wb_r_o=2, result_o=89abcdef, gnt_o=0; the cycle after, wb_o=0.
- v0_i=v1_i=1 in the same cycle (r=3/32'h11111111, r=4/32'h22222222), held while stalled -> wb writes r3 then r4 in consecutive cycles; stall1_o=1 for exactly one cycle.
- Both ports valid continuously for 6 cycles with distinct data -> gnt_o sequence 0,1,0,1,0,1 and no lost or duplicated writes.
- Port 1 alone streams 5 values back-to-back -> 5 consecutive wb_o=1, stall1_o stays 0.
- Conflict leaves port 1 pending, then reset=1 for one cycle -> port 1 entry never appears on wb; all outputs return to reset values; the next conflict grants port 0 first.
- With WB_FIXED_PRIO_EN defined, both ports valid continuously for 4 cycles -> gnt_o=0 every cycle, stall1_o=1 throughout.
